// File: rtl/text_render_ctrl.sv
// Text-mode pixel pipeline: cell/font address generation, glyph bit select, reverse video, blinking cursor.
// Latency 3 pixel clocks from pixel_x/y to rgb (syncs matched); no backpressure, one pixel per cycle.
module text_render_ctrl #(
    parameter int          BLINK_FRAMES = 30,
    parameter int          CURSOR_ROW   = 14,
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_x,
    input  logic [4:0]  cursor_y,
    output logic [11:0] text_addr,
    input  logic [7:0]  text_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on
);

    localparam logic [3:0] CUR_ROW    = 4'(CURSOR_ROW);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    // Stage 1 / stage 2 pipeline registers
    logic [2:0]  col_d1_q, col_d2_q;
    logic [3:0]  row_d1_q, row_d2_q;
    logic        match_d1_q, match_d2_q;
    logic        von_d1_q, von_d2_q, von_q;
    logic        hs_d1_q, hs_d2_q, hs_q;
    logic        vs_d1_q, vs_d2_q, vs_q;
    logic        rev_d2_q;
    logic [11:0] rgb_q, rgb_d;

    logic        vs_prev_q;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        blink_q, blink_d;

    logic        match0;
    logic        pix;
    logic        unused_pixel_y9;

    assign unused_pixel_y9 = pixel_y[9];

    assign text_addr = {pixel_y[8:4], pixel_x[9:3]};
    assign font_addr = {text_data[6:0], row_d1_q};
    assign match0    = (pixel_x[9:3] == cursor_x) && (pixel_y[8:4] == cursor_y);

    always_comb begin
        pix = font_data[3'd7 - col_d2_q];
        if (rev_d2_q) begin
            pix = ~pix;
        end
        // Cursor underline wins over reverse video
        if (cursor_en && blink_q && match_d2_q && (row_d2_q >= CUR_ROW)) begin
            pix = 1'b1;
        end
        rgb_d = von_d2_q ? (pix ? FG_COLOR : BG_COLOR) : 12'h000;
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (vs_prev_q && !vsync_in) begin
            if (frame_cnt_q == BLINK_LAST) begin
                frame_cnt_d = 8'd0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_d1_q    <= '0;
            row_d1_q    <= '0;
            match_d1_q  <= 1'b0;
            von_d1_q    <= 1'b0;
            hs_d1_q     <= 1'b1;
            vs_d1_q     <= 1'b1;
            col_d2_q    <= '0;
            row_d2_q    <= '0;
            match_d2_q  <= 1'b0;
            von_d2_q    <= 1'b0;
            hs_d2_q     <= 1'b1;
            vs_d2_q     <= 1'b1;
            rev_d2_q    <= 1'b0;
            rgb_q       <= 12'h000;
            von_q       <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            vs_prev_q   <= 1'b1;
            frame_cnt_q <= 8'd0;
            blink_q     <= 1'b1;
        end else begin
            col_d1_q    <= pixel_x[2:0];
            row_d1_q    <= pixel_y[3:0];
            match_d1_q  <= match0;
            von_d1_q    <= video_on_in;
            hs_d1_q     <= hsync_in;
            vs_d1_q     <= vsync_in;
            col_d2_q    <= col_d1_q;
            row_d2_q    <= row_d1_q;
            match_d2_q  <= match_d1_q;
            von_d2_q    <= von_d1_q;
            hs_d2_q     <= hs_d1_q;
            vs_d2_q     <= vs_d1_q;
            rev_d2_q    <= text_data[7];
            rgb_q       <= rgb_d;
            von_q       <= von_d2_q;
            hs_q        <= hs_d2_q;
            vs_q        <= vs_d2_q;
            vs_prev_q   <= vsync_in;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign rgb      = rgb_q;
    assign hsync    = hs_q;
    assign vsync    = vs_q;
    assign video_on = von_q;

endmodule

// File: tb/tb_text_render_ctrl.sv
// Directed bench for text_render_ctrl with registered text RAM / font ROM models.
module tb_text_render_ctrl;

    logic        clk;
    logic        rst_n;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on_in, hsync_in, vsync_in;
    logic        cursor_en;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic [11:0] text_addr;
    logic [7:0]  text_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [11:0] rgb;
    logic        hsync, vsync, video_on;

    logic [7:0]  txt_val;
    int          n_tests = 0;
    int          n_fail  = 0;

    text_render_ctrl #(
        .BLINK_FRAMES(2),
        .CURSOR_ROW  (14),
        .FG_COLOR    (12'hFFF),
        .BG_COLOR    (12'h000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on_in(video_on_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .cursor_en  (cursor_en),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .text_addr  (text_addr),
        .text_data  (text_data),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .rgb        (rgb),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] font_fn(input logic [10:0] a);
        if (a[10:4] == 7'h7F)     return 8'hFF;
        else if (a == 11'h013)    return 8'b1010_0101;
        else                      return 8'h00;
    endfunction

    // One-cycle registered reads, like the real RAM/ROM
    always @(posedge clk) begin
        text_data <= txt_val;
        font_data <= font_fn(font_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive 8 consecutive pixels; exp_bits[7] is the first pixel's expected on/off.
    task automatic sweep(input string tag, input logic [9:0] y, input logic [9:0] x0,
                         input logic [7:0] exp_bits, input logic chk_fa, input logic [10:0] exp_fa);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                pixel_x     = x0 + 10'(i);
                pixel_y     = y;
                video_on_in = 1'b1;
            end else begin
                video_on_in = 1'b0;
            end
            step();
            if (i == 0 && chk_fa) check({tag, "_font_addr"}, 32'(font_addr), 32'(exp_fa));
            if (i >= 2) check(tag, 32'(rgb), exp_bits[9-i] ? 32'hFFF : 32'h000);
        end
    endtask

    task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y, input logic [11:0] exp);
        pixel_x     = x;
        pixel_y     = y;
        video_on_in = 1'b1;
        step();
        video_on_in = 1'b0;
        step();
        step();
        check(tag, 32'(rgb), 32'(exp));
    endtask

    task automatic frame_edge();
        vsync_in = 1'b0;
        repeat (4) step();
        vsync_in = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        video_on_in = 1'b0;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        cursor_en   = 1'b0;
        cursor_x    = '0;
        cursor_y    = '0;
        txt_val     = 8'h00;
        repeat (3) step();
        check("rst_rgb",      32'(rgb),      32'h000);
        check("rst_hsync",    32'(hsync),    32'h1);
        check("rst_vsync",    32'(vsync),    32'h1);
        check("rst_video_on", 32'(video_on), 32'h0);
        rst_n = 1'b1;

        pixel_x = 10'd17;
        pixel_y = 10'd35;
        #1;
        check("text_addr_17_35", 32'(text_addr), 32'h102);
        pixel_x = 10'd639;
        pixel_y = 10'd479;
        #1;
        check("text_addr_639_479", 32'(text_addr), 32'hECF);
        step();

        txt_val = 8'h01;
        repeat (2) step();
        sweep("glyph", 10'd3, 10'd0, 8'b1010_0101, 1'b1, 11'h013);

        txt_val = 8'h81;
        repeat (2) step();
        sweep("reverse", 10'd3, 10'd0, 8'b0101_1010, 1'b1, 11'h013);

        txt_val   = 8'h00;
        cursor_en = 1'b1;
        cursor_x  = 7'd2;
        cursor_y  = 5'd1;
        repeat (2) step();
        sweep("cursor_row30", 10'd30, 10'd16, 8'hFF, 1'b0, 11'h000);
        sweep("cursor_row31", 10'd31, 10'd16, 8'hFF, 1'b0, 11'h000);
        sweep("cursor_row29", 10'd29, 10'd16, 8'h00, 1'b0, 11'h000);
        probe("cursor_x24", 10'd24, 10'd30, 12'h000);

        cursor_en = 1'b0;
        probe("cursor_disabled", 10'd16, 10'd30, 12'h000);
        cursor_en = 1'b1;
        cursor_x  = 7'd100;
        probe("cursor_out_of_range", 10'd16, 10'd30, 12'h000);
        cursor_x  = 7'd2;
        probe("blink_edge0", 10'd16, 10'd30, 12'hFFF);

        // BLINK_FRAMES=2: visibility after edges 1..5 = on, off, off, on, on
        frame_edge(); probe("blink_edge1", 10'd16, 10'd30, 12'hFFF);
        frame_edge(); probe("blink_edge2", 10'd16, 10'd30, 12'h000);
        frame_edge(); probe("blink_edge3", 10'd16, 10'd30, 12'h000);
        frame_edge(); probe("blink_edge4", 10'd16, 10'd30, 12'hFFF);
        frame_edge(); probe("blink_edge5", 10'd16, 10'd30, 12'hFFF);
        cursor_en = 1'b0;

        txt_val = 8'h7F;
        repeat (2) step();
        pixel_x     = 10'd100;
        pixel_y     = 10'd100;
        video_on_in = 1'b0;
        repeat (3) step();
        check("blank_rgb",      32'(rgb),      32'h000);
        check("blank_video_on", 32'(video_on), 32'h0);
        probe("unblank_rgb", 10'd100, 10'd100, 12'hFFF);

        for (int c = 0; c < 115; c++) begin
            hsync_in = !(c >= 10 && c <= 105);
            step();
            if (c + 1 == 12 || c + 1 == 13 || c + 1 == 60 || c + 1 == 108 || c + 1 == 109)
                check($sformatf("hsync_cyc%0d", c + 1), 32'(hsync),
                      (c + 1 >= 13 && c + 1 <= 108) ? 32'h0 : 32'h1);
        end

        // Mid-frame async reset, then pipeline refill
        pixel_x     = 10'd200;
        pixel_y     = 10'd200;
        video_on_in = 1'b1;
        repeat (4) step();
        check("pre_reset_rgb", 32'(rgb), 32'hFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_rgb", 32'(rgb), 32'h000);
        hsync_in = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("refill0_rgb", 32'(rgb), 32'h000);
        step();
        check("refill1_rgb",   32'(rgb),   32'h000);
        check("refill1_hsync", 32'(hsync), 32'h1);
        step();
        check("refill2_rgb",   32'(rgb),   32'h000);
        check("refill2_hsync", 32'(hsync), 32'h1);
        step();
        check("refill3_rgb",   32'(rgb),   32'hFFF);
        check("refill3_hsync", 32'(hsync), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
